// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-frame instruction cache with hit/miss counters
module icache #(
   parameter int NSETS = 16,
   parameter int IDX_W = $clog2(NSETS)
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload,
   input  logic        flush,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic {IDLE, FILL} state_t;

   state_t                  state_q, state_d;
   logic [29:0]             miss_addr_q, miss_addr_d;
   logic [31:0]             hit_count_q, miss_count_q;
   logic [NSETS-1:0]        valid_q;
   logic [TAG_W-1:0]        tag_q  [NSETS];
   logic [31:0]             data_q [NSETS];

   logic [IDX_W-1:0]        req_idx, fill_idx;
   logic [TAG_W-1:0]        req_tag, fill_tag;
   logic                    hit, miss, fill_we;
   logic                    unused_bits;

   assign req_idx     = imemaddr[IDX_W+1:2];
   assign req_tag     = imemaddr[31:IDX_W+2];
   assign fill_idx    = miss_addr_q[IDX_W-1:0];
   assign fill_tag    = miss_addr_q[29:IDX_W];
   assign unused_bits = ^imemaddr[1:0];
   assign hit_count   = hit_count_q;
   assign miss_count  = miss_count_q;

   // Lookup, miss detection and fill sequencing; flush overrides everything else
   always_comb begin
      state_d     = state_q;
      miss_addr_d = miss_addr_q;
      hit         = 1'b0;
      miss        = 1'b0;
      fill_we     = 1'b0;
      ihit        = 1'b0;
      imemload    = 32'h0;
      iREN        = 1'b0;
      iaddr       = 32'h0;
      case (state_q)
         IDLE: begin
            if (imemREN && !flush) begin
               if (valid_q[req_idx] && (tag_q[req_idx] == req_tag)) begin
                  hit      = 1'b1;
                  ihit     = 1'b1;
                  imemload = data_q[req_idx];
               end else begin
                  miss        = 1'b1;
                  miss_addr_d = imemaddr[31:2];
                  state_d     = FILL;
               end
            end
         end
         FILL: begin
            iREN  = 1'b1;
            iaddr = {miss_addr_q, 2'b00};
            if (!imemREN) begin
               state_d = IDLE;
            end else if (!iwait) begin
               fill_we = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d = IDLE;
         fill_we = 1'b0;
      end
   end

   // State, miss address and performance counters
   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         state_q      <= IDLE;
         miss_addr_q  <= 30'h0;
         hit_count_q  <= 32'h0;
         miss_count_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         miss_addr_q <= miss_addr_d;
         if (hit)  hit_count_q  <= hit_count_q + 32'd1;
         if (miss) miss_count_q <= miss_count_q + 32'd1;
      end
   end

   // Valid bits: cleared by reset or flush, set by a completed fill
   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         valid_q <= '0;
      end else if (flush) begin
         valid_q <= '0;
      end else if (fill_we) begin
         valid_q[fill_idx] <= 1'b1;
      end
   end

   // Tag and data storage, written only on fill completion
   always_ff @(posedge CLK) begin
      if (fill_we) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= iload;
      end
   end

endmodule
